// File: rtl/uart_tx_arbiter.sv
// Round-robin, whole-message sharing of the UART TX FIFO write port; grant 1 cycle after request, write 1 cycle after handshake.
// Backpressure: req_ready drops while credits (modelled TX FIFO space, refilled once per character time) are exhausted.
module uart_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_MSG_LEN     = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_fifo_data_in,
  output logic                 tx_fifo_write_en,
  output logic                 busy
);

  localparam int BAUD_DIVISOR  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int REFILL_PERIOD = 11 * BAUD_DIVISOR;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_MSG_LEN > 1) ? $clog2(MAX_MSG_LEN) : 1;

  typedef enum logic {ARB, SEND} state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cur;
  logic [IW-1:0] next_idx;
  logic [IW-1:0] cand;
  logic          found;
  logic [CW-1:0] credits;
  logic [RW-1:0] refill_cnt;
  logic [BW-1:0] byte_count;
  logic          refill;
  logic          hs;
  logic [7:0]    cur_data;
  logic          msg_end;

  // Search upward from the requester after the last one served, wrapping.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  assign req_ready = (state == SEND && credits != '0) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign cur_data  = req_data[{cur, 3'b000} +: 8];
  assign msg_end   = req_last[cur] || (byte_count == BW'(MAX_MSG_LEN - 1));
  assign refill    = (refill_cnt == RW'(REFILL_PERIOD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ARB;
      grant            <= '0;
      last_grant       <= IW'(NUM_REQ - 1);
      cur              <= '0;
      byte_count       <= '0;
      credits          <= CW'(FIFO_DEPTH);
      refill_cnt       <= '0;
      tx_fifo_write_en <= 1'b0;
      tx_fifo_data_in  <= 8'h00;
      busy             <= 1'b0;
    end else begin
      refill_cnt <= refill ? '0 : refill_cnt + RW'(1);

      // A refill and a write in the same cycle cancel out.
      if (refill && !hs) begin
        if (credits != CW'(FIFO_DEPTH))
          credits <= credits + CW'(1);
      end else if (hs && !refill) begin
        credits <= credits - CW'(1);
      end

      tx_fifo_write_en <= hs;
      if (hs)
        tx_fifo_data_in <= cur_data;

      case (state)
        ARB: begin
          if (found) begin
            state      <= SEND;
            grant      <= NUM_REQ'(1) << next_idx;
            cur        <= next_idx;
            byte_count <= '0;
            busy       <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            byte_count <= byte_count + BW'(1);
            if (msg_end) begin
              state      <= ARB;
              grant      <= '0;
              last_grant <= cur;
              busy       <= 1'b0;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port between `NUM_REQ` byte-stream requesters (status reporter, command responder, debug dumper, ...). Grants are round-robin and held for a whole message, so bytes from different requesters never interleave on the line. A credit counter models the TX FIFO drain rate, so the arbiter never writes into a full TX FIFO; the UART exposes no full flag. The block sits between the requester logic in the top module and the `uart` instance's `tx_fifo_data_in`/`tx_fifo_write_en` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLOCK_FREQUENCY`, 27000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: UART baud rate.
- `FIFO_DEPTH`, 64: depth of the UART TX FIFO; also the maximum credit count.
- `MAX_MSG_LEN`, 64: maximum bytes per grant; the grant is forcibly released after this many bytes.
- `clock` input 1: system clock. One clock domain only.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: bit i set means requester i presents a byte.
- `req_data` input 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` input NUM_REQ: bit i marks the presented byte as the final byte of the message.
- `req_ready` output NUM_REQ: bit i means the byte of requester i is accepted this cycle. Combinational.
- `grant` output NUM_REQ: one-hot registered grant vector; all zero when no requester holds the grant.
- `tx_fifo_data_in` output 8: byte to the UART TX FIFO. Registered.
- `tx_fifo_write_en` output 1: one-cycle write strobe to the UART TX FIFO. Registered.
- `busy` output 1: set while in SEND. Registered.

## Operation
- Derived constants:
  - BAUD_DIVISOR = CLOCK_FREQUENCY/BAUD_RATE (integer division).
  - REFILL_PERIOD = 11*BAUD_DIVISOR, which is 10 bit times plus one bit of margin.
- State machine with two states, ARB and SEND.
- ARB state:
  - If no `req_valid` bit is set, stay in ARB.
  - Otherwise select the first set `req_valid` bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Register `grant` to that one-hot value, clear `byte_count`, and go to SEND.
- SEND state:
  - `req_ready[i] = grant[i] & (credits != 0)`.
  - A handshake occurs when `req_valid[i] & req_ready[i]`.
  - On a handshake: write `req_data[i]` to the TX FIFO, decrement credits, and increment `byte_count`.
  - If `req_last[i]` is set, or `byte_count` reaches MAX_MSG_LEN-1 (the last permitted byte): set `last_grant <= i`, clear `grant`, and return to ARB.
  - A requester that deasserts `req_valid` mid-message keeps the grant. A message is closed only by `req_last` or by the length cap; there is no idle timeout.
- Credits:
  - Width is clog2(FIFO_DEPTH+1). Reset value is FIFO_DEPTH.
  - A free-running refill counter counts 0..REFILL_PERIOD-1. At wrap it adds one credit, saturating at FIFO_DEPTH.
  - Refill and write in the same cycle leave credits unchanged.
  - Credits never underflow, because `req_ready` is low at credits = 0.
- `req_ready` is zero in ARB, so no byte is accepted on the arbitration cycle.

## Timing
- Reset values:
  - `grant`, `req_ready`, `tx_fifo_write_en`, `tx_fifo_data_in`, `busy`: 0.
  - State: ARB. `last_grant` = NUM_REQ-1, so requester 0 wins first. Credits = FIFO_DEPTH. Refill counter = 0.
- Arbitration latency: `req_valid` seen in ARB in cycle N, `grant` and `busy` high in cycle N+1, earliest handshake in cycle N+1.
- Write latency: handshake in cycle N, `tx_fifo_write_en` = 1 with the byte in cycle N+1. `tx_fifo_write_en` is high for exactly one cycle per handshake.
- Back-to-back: one byte per cycle while credits > 0.
- Message turnaround: handshake with `req_last` in cycle N, ARB in cycle N+1, next grant in cycle N+2.
- Reset mid-message: the pending grant is dropped and the message is truncated. A write strobe already registered in the reset cycle is cleared. No further bytes are written.
- Simultaneous requests are resolved by round-robin only; no requester is starved beyond NUM_REQ-1 messages.

## Test plan
- Single requester: requester 0 sends "OK\r\n" with `req_last` on '\n' -> four `tx_fifo_write_en` pulses carrying 0x4F, 0x4B, 0x0D, 0x0A on consecutive cycles; `grant` returns to 0 one cycle after the last handshake.
- Fairness: all four requesters continuously send 2-byte messages -> grant order 0, 1, 2, 3, 0, ...; no bytes interleave within a message.
- Credit exhaustion: requester 1 sends a 100-byte message with MAX_MSG_LEN = 128 -> 64 writes back-to-back, then `req_ready` low; afterwards one write per 11*234 = 2574 cycles.
- Length cap: requester 2 streams 70 bytes without `req_last`, MAX_MSG_LEN = 64 -> grant released after byte 64. If requester 3 is valid, it is granted before requester 2's remaining 6 bytes.
- Stall: the granted requester drops `req_valid` for 50 cycles mid-message while others are valid -> the grant is held and no writes occur; the message resumes when `req_valid` returns.
- Reset mid-message: assert `reset` during byte 3 of a 10-byte message -> all outputs 0 the following cycle and credits = 64. After release, requester 0 wins the first arbitration.
